// File: rtl/imm_gen_pipe.sv
// Pipelined RV32I/RV64I immediate generator with a two-entry (main + skid) output buffer.
// Define IMM_GEN_ILLEGAL_EN to flag unmapped opcodes as ILL and latch err_sticky on their emit.
module imm_gen_pipe #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic [XLEN-1:0] out_target,
  output logic            out_illegal,
  output logic            err_sticky
);

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;
`ifdef IMM_GEN_ILLEGAL_EN
  localparam logic [2:0] FMT_ILL = 3'd6;
`endif

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic [XLEN-1:0] target;
    logic            ill;
  } entry_t;

  function automatic logic signed [XLEN-1:0] sext32(input logic signed [31:0] v);
    return XLEN'(v);
  endfunction

  logic [6:0]             opc;
  logic [2:0]             f3;
  logic                   mapped;
  logic signed [XLEN-1:0] imm_s;
  entry_t                 dec;

  always_comb begin
    opc     = in_instr[6:0];
    f3      = in_instr[14:12];
    mapped  = 1'b1;
    imm_s   = '0;
    dec     = '0;
    dec.fmt = FMT_R;
    case (opc)
      7'b0110011: dec.fmt = FMT_R;
      7'b0000011, 7'b1100111, 7'b1110011: begin
        dec.fmt = FMT_I;
        imm_s   = sext32({{20{in_instr[31]}}, in_instr[31:20]});
      end
      7'b0010011: begin
        dec.fmt = FMT_I;
        // Shift-immediates carry only shamt; funct7 bits (incl. instr[30]) are dropped.
        if (f3 == 3'b001 || f3 == 3'b101) begin
          if (XLEN == 64) imm_s[5:0] = in_instr[25:20];
          else            imm_s[4:0] = in_instr[24:20];
        end else begin
          imm_s = sext32({{20{in_instr[31]}}, in_instr[31:20]});
        end
      end
      7'b0100011: begin
        dec.fmt = FMT_S;
        imm_s   = sext32({{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]});
      end
      7'b1100011: begin
        dec.fmt = FMT_B;
        imm_s   = sext32({{20{in_instr[31]}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0});
      end
      7'b0110111, 7'b0010111: begin
        dec.fmt = FMT_U;
        imm_s   = sext32({in_instr[31:12], 12'b0});
      end
      7'b1101111: begin
        dec.fmt = FMT_J;
        imm_s   = sext32({{12{in_instr[31]}}, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0});
      end
      7'b0011011: begin
        if (XLEN == 64) begin
          dec.fmt = FMT_I;
          if (f3 == 3'b001 || f3 == 3'b101) imm_s[4:0] = in_instr[24:20];
          else imm_s = sext32({{20{in_instr[31]}}, in_instr[31:20]});
        end else begin
          mapped = 1'b0;
        end
      end
      7'b0111011: begin
        if (XLEN == 64) dec.fmt = FMT_R;
        else            mapped  = 1'b0;
      end
      default: mapped = 1'b0;
    endcase
`ifdef IMM_GEN_ILLEGAL_EN
    if (!mapped || in_instr[1:0] != 2'b11) begin
      dec.fmt = FMT_ILL;
      imm_s   = '0;
      dec.ill = 1'b1;
    end
`else
    if (!mapped) begin
      dec.fmt = FMT_R;
      imm_s   = '0;
    end
`endif
    dec.imm    = $unsigned(imm_s);
    dec.target = in_pc + $unsigned(imm_s);
  end

  entry_t m_q, m_d, k_q, k_d;
  logic   m_vld_q, m_vld_d, k_vld_q, k_vld_d;
  logic   rdy_q, rdy_d, err_q, err_d;
  logic   accept, emit;

  assign in_ready = rdy_q & ~reset;
  assign accept   = in_valid & in_ready;
  assign emit     = m_vld_q & out_ready;

  // Buffer steering: M refills from K first so FIFO order holds; K only fills while M stalls.
  always_comb begin
    m_d     = m_q;
    k_d     = k_q;
    m_vld_d = m_vld_q;
    k_vld_d = k_vld_q;
    if (!m_vld_q || emit) begin
      if (k_vld_q) begin
        m_d     = k_q;
        m_vld_d = 1'b1;
        if (accept) k_d = dec;
        else        k_vld_d = 1'b0;
      end else begin
        m_vld_d = accept;
        if (accept) m_d = dec;
      end
    end else if (accept) begin
      k_d     = dec;
      k_vld_d = 1'b1;
    end
    rdy_d = ~k_vld_d;
    err_d = err_q | (emit & m_q.ill);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      m_q     <= '0;
      m_vld_q <= 1'b0;
      k_vld_q <= 1'b0;
      rdy_q   <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      m_q     <= m_d;
      m_vld_q <= m_vld_d;
      k_vld_q <= k_vld_d;
      rdy_q   <= rdy_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    k_q <= k_d;
  end

  assign out_valid   = m_vld_q;
  assign out_imm     = m_q.imm;
  assign out_fmt     = m_q.fmt;
  assign out_target  = m_q.target;
  assign out_illegal = m_q.ill;
  assign err_sticky  = err_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed self-checking bench for imm_gen_pipe (XLEN=32).
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_imm;
  logic [2:0]  out_fmt;
  logic [31:0] out_target;
  logic        out_illegal;
  logic        err_sticky;

  int checks   = 0;
  int failures = 0;

  imm_gen_pipe #(.XLEN(32)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_imm(out_imm), .out_fmt(out_fmt), .out_target(out_target),
    .out_illegal(out_illegal), .err_sticky(err_sticky)
  );

  always #5 clk = ~clk;

  // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one instruction for a single edge with out_ready=1.
  task automatic send_one(input logic [31:0] instr, input logic [31:0] pc);
    in_valid  = 1'b1;
    in_instr  = instr;
    in_pc     = pc;
    out_ready = 1'b1;
    step();
    in_valid  = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b1;
    step(); step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL rst_in_ready got=%b exp=0", in_ready); end
    checks++; if (out_imm !== 32'h0) begin failures++; $display("FAIL rst_imm got=%h exp=0", out_imm); end
    checks++; if (out_fmt !== 3'd0) begin failures++; $display("FAIL rst_fmt got=%0d exp=0", out_fmt); end
    checks++; if (out_target !== 32'h0) begin failures++; $display("FAIL rst_target got=%h exp=0", out_target); end
    checks++; if (out_illegal !== 1'b0) begin failures++; $display("FAIL rst_illegal got=%b exp=0", out_illegal); end
    checks++; if (err_sticky !== 1'b0) begin failures++; $display("FAIL rst_err got=%b exp=0", err_sticky); end
    reset = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_release_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_formats();
    send_one(32'hFFF00093, 32'h0);   // addi x1,x0,-1
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL i_valid got=%b exp=1", out_valid); end
    checks++; if (out_imm !== 32'hFFFFFFFF) begin failures++; $display("FAIL i_imm got=%h exp=ffffffff", out_imm); end
    checks++; if (out_fmt !== 3'd1) begin failures++; $display("FAIL i_fmt got=%0d exp=1", out_fmt); end
    checks++; if (out_target !== 32'hFFFFFFFF) begin failures++; $display("FAIL i_target got=%h exp=ffffffff", out_target); end
    send_one(32'hFE112E23, 32'h40);  // sw x1,-4(x2)
    checks++; if (out_imm !== 32'hFFFFFFFC) begin failures++; $display("FAIL s_imm got=%h exp=fffffffc", out_imm); end
    checks++; if (out_fmt !== 3'd2) begin failures++; $display("FAIL s_fmt got=%0d exp=2", out_fmt); end
    checks++; if (out_target !== 32'h3C) begin failures++; $display("FAIL s_target got=%h exp=3c", out_target); end
    send_one(32'hFE000CE3, 32'h100); // beq x0,x0,-8
    checks++; if (out_imm !== 32'hFFFFFFF8) begin failures++; $display("FAIL b_imm got=%h exp=fffffff8", out_imm); end
    checks++; if (out_fmt !== 3'd3) begin failures++; $display("FAIL b_fmt got=%0d exp=3", out_fmt); end
    checks++; if (out_target !== 32'hF8) begin failures++; $display("FAIL b_target got=%h exp=f8", out_target); end
    send_one(32'h12345037, 32'h8);   // lui x0,0x12345
    checks++; if (out_imm !== 32'h12345000) begin failures++; $display("FAIL u_imm got=%h exp=12345000", out_imm); end
    checks++; if (out_fmt !== 3'd4) begin failures++; $display("FAIL u_fmt got=%0d exp=4", out_fmt); end
    checks++; if (out_target !== 32'h12345008) begin failures++; $display("FAIL u_target got=%h exp=12345008", out_target); end
    send_one(32'h80000017, 32'h80000000); // auipc x0,0x80000: carry out dropped
    checks++; if (out_imm !== 32'h80000000) begin failures++; $display("FAIL auipc_imm got=%h exp=80000000", out_imm); end
    checks++; if (out_target !== 32'h0) begin failures++; $display("FAIL auipc_wrap got=%h exp=0", out_target); end
    send_one(32'hFFDFF06F, 32'h200); // jal x0,-4
    checks++; if (out_imm !== 32'hFFFFFFFC) begin failures++; $display("FAIL j_imm got=%h exp=fffffffc", out_imm); end
    checks++; if (out_fmt !== 3'd5) begin failures++; $display("FAIL j_fmt got=%0d exp=5", out_fmt); end
    checks++; if (out_target !== 32'h1FC) begin failures++; $display("FAIL j_target got=%h exp=1fc", out_target); end
    send_one(32'h003100B3, 32'h30);  // add x1,x2,x3
    checks++; if (out_imm !== 32'h0) begin failures++; $display("FAIL r_imm got=%h exp=0", out_imm); end
    checks++; if (out_fmt !== 3'd0) begin failures++; $display("FAIL r_fmt got=%0d exp=0", out_fmt); end
    checks++; if (out_target !== 32'h30) begin failures++; $display("FAIL r_target got=%h exp=30", out_target); end
  endtask

  task automatic test_shift_imm();
    send_one(32'h4030D093, 32'h10);  // srai x1,x1,3
    checks++; if (out_imm !== 32'h3) begin failures++; $display("FAIL srai_imm got=%h exp=3", out_imm); end
    checks++; if (out_fmt !== 3'd1) begin failures++; $display("FAIL srai_fmt got=%0d exp=1", out_fmt); end
    checks++; if (out_target !== 32'h13) begin failures++; $display("FAIL srai_target got=%h exp=13", out_target); end
    send_one(32'h01F09093, 32'h0);   // slli x1,x1,31
    checks++; if (out_imm !== 32'h1F) begin failures++; $display("FAIL slli_imm got=%h exp=1f", out_imm); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_instr  = 32'h00100093; in_pc = 32'h0; step();
    checks++; if (out_imm !== 32'h1 || out_valid !== 1'b1) begin failures++; $display("FAIL b2b_0 got=%h/%b exp=1/1", out_imm, out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready got=%b exp=1", in_ready); end
    in_instr  = 32'h00200093; step();
    checks++; if (out_imm !== 32'h2 || out_valid !== 1'b1) begin failures++; $display("FAIL b2b_1 got=%h/%b exp=2/1", out_imm, out_valid); end
    in_instr  = 32'h00300093; step();
    checks++; if (out_imm !== 32'h3 || out_valid !== 1'b1) begin failures++; $display("FAIL b2b_2 got=%h/%b exp=3/1", out_imm, out_valid); end
    in_valid  = 1'b0; step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'h00100093; in_pc = 32'h0; step();   // A -> M
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_ready_a got=%b exp=1", in_ready); end
    in_instr  = 32'h00200093; step();                  // B -> K
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_ready_b got=%b exp=0", in_ready); end
    in_instr  = 32'h00300093; step();                  // C stalled
    checks++; if (out_imm !== 32'h1 || out_valid !== 1'b1) begin failures++; $display("FAIL bp_hold1 got=%h/%b exp=1/1", out_imm, out_valid); end
    step();
    checks++; if (out_imm !== 32'h1 || in_ready !== 1'b0) begin failures++; $display("FAIL bp_hold2 got=%h/%b exp=1/0", out_imm, in_ready); end
    out_ready = 1'b1; step();                          // emit A, B -> M
    checks++; if (out_imm !== 32'h2 || out_valid !== 1'b1) begin failures++; $display("FAIL bp_b got=%h/%b exp=2/1", out_imm, out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_ready_ret got=%b exp=1", in_ready); end
    step();                                            // emit B, accept C -> M
    checks++; if (out_imm !== 32'h3 || out_valid !== 1'b1) begin failures++; $display("FAIL bp_c got=%h/%b exp=3/1", out_imm, out_valid); end
    in_valid = 1'b0; step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_illegal();
    send_one(32'h00000000, 32'h44);
`ifdef IMM_GEN_ILLEGAL_EN
    checks++; if (out_fmt !== 3'd6) begin failures++; $display("FAIL ill_fmt got=%0d exp=6", out_fmt); end
    checks++; if (out_illegal !== 1'b1) begin failures++; $display("FAIL ill_flag got=%b exp=1", out_illegal); end
    checks++; if (err_sticky !== 1'b0) begin failures++; $display("FAIL ill_err_early got=%b exp=0", err_sticky); end
    step();
    checks++; if (err_sticky !== 1'b1) begin failures++; $display("FAIL ill_err got=%b exp=1", err_sticky); end
`else
    checks++; if (out_fmt !== 3'd0) begin failures++; $display("FAIL unmapped_fmt got=%0d exp=0", out_fmt); end
    checks++; if (out_illegal !== 1'b0) begin failures++; $display("FAIL unmapped_flag got=%b exp=0", out_illegal); end
    step();
    checks++; if (err_sticky !== 1'b0) begin failures++; $display("FAIL unmapped_err got=%b exp=0", err_sticky); end
`endif
    checks++; if (out_imm !== 32'h0) begin failures++; $display("FAIL unmapped_imm got=%h exp=0", out_imm); end
    checks++; if (out_target !== 32'h44) begin failures++; $display("FAIL unmapped_target got=%h exp=44", out_target); end
  endtask

  task automatic test_reset_full();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'h00100093; step();
    in_instr  = 32'h00200093; step();
    in_valid  = 1'b0;
    checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin failures++; $display("FAIL rf_full got=%b/%b exp=0/1", in_ready, out_valid); end
    reset = 1'b1; step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rf_valid got=%b exp=0", out_valid); end
    checks++; if (err_sticky !== 1'b0) begin failures++; $display("FAIL rf_err got=%b exp=0", err_sticky); end
    checks++; if (out_imm !== 32'h0) begin failures++; $display("FAIL rf_imm got=%h exp=0", out_imm); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL rf_ready_in_rst got=%b exp=0", in_ready); end
    reset = 1'b0; out_ready = 1'b1; #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rf_ready_rel got=%b exp=1", in_ready); end
    step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rf_discard got=%b exp=0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_formats();
    test_shift_imm();
    test_back_to_back();
    test_backpressure();
    test_illegal();
    test_reset_full();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
